// File: rtl/set12.sv
// Clock-setting controller: set/up/down buttons edit a 12-hour time (hours, minutes, AM/PM).
// Optional auto-repeat on held up/down buttons is enabled by defining SET12_AUTOREPEAT_EN.
module set12 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set,
    input  logic       up,
    input  logic       down,
    output logic       propagate,
    output logic       isPM,
    output logic [3:0] hours,
    output logic [5:0] minutes
);

    localparam int unsigned HOUR_W = 4;
    localparam int unsigned MIN_W  = 6;

    typedef enum logic {
        ST_HOUR   = 1'b0,
        ST_MINUTE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [HOUR_W-1:0]   hours_q, hours_d;
    logic [MIN_W-1:0]    minutes_q, minutes_d;
    logic                is_pm_q, is_pm_d;
    logic                propagate_q, propagate_d;
    logic                prev_set_q, prev_up_q, prev_down_q;

    logic set_press_c;
    logic up_press_c;
    logic down_press_c;

    assign set_press_c = set & ~prev_set_q;

`ifdef SET12_AUTOREPEAT_EN
    localparam int unsigned HOLD_W = 5;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              up_held_c;
    logic              down_held_c;
    logic              repeat_c;

    assign up_held_c   = up & prev_up_q;
    assign down_held_c = down & prev_down_q;
    assign repeat_c    = (up_held_c | down_held_c) && (hold_cnt_q == HOLD_W'(16));

    // Counter starts at 1 on a press; first repeat after 16 held cycles, then every 4.
    always_comb begin
        hold_cnt_d = '0;
        if (set_press_c) begin
            hold_cnt_d = '0;
        end else if ((up & ~prev_up_q) | (down & ~prev_down_q)) begin
            hold_cnt_d = HOLD_W'(1);
        end else if (up_held_c | down_held_c) begin
            hold_cnt_d = repeat_c ? HOLD_W'(13) : HOLD_W'(hold_cnt_q + HOLD_W'(1));
        end
    end

    assign up_press_c   = (up & ~prev_up_q) | (up_held_c & repeat_c);
    assign down_press_c = (down & ~prev_down_q) | (down_held_c & repeat_c);
`else
    assign up_press_c   = up & ~prev_up_q;
    assign down_press_c = down & ~prev_down_q;
`endif

    // Next-state and field update; set wins, up+down together cancel.
    always_comb begin
        state_d     = state_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        is_pm_d     = is_pm_q;
        propagate_d = 1'b0;

        if (set_press_c) begin
            if (state_q == ST_HOUR) begin
                state_d = ST_MINUTE;
            end else begin
                state_d     = ST_HOUR;
                propagate_d = 1'b1;
            end
        end else if (up_press_c && !down_press_c) begin
            if (state_q == ST_HOUR) begin
                if (hours_q == HOUR_W'(12)) begin
                    hours_d = HOUR_W'(1);
                end else if (hours_q == HOUR_W'(11)) begin
                    hours_d = HOUR_W'(12);
                    is_pm_d = ~is_pm_q;
                end else begin
                    hours_d = HOUR_W'(hours_q + HOUR_W'(1));
                end
            end else begin
                minutes_d = (minutes_q == MIN_W'(59)) ? '0 : MIN_W'(minutes_q + MIN_W'(1));
            end
        end else if (down_press_c && !up_press_c) begin
            if (state_q == ST_HOUR) begin
                if (hours_q == HOUR_W'(1)) begin
                    hours_d = HOUR_W'(12);
                end else if (hours_q == HOUR_W'(12)) begin
                    hours_d = HOUR_W'(11);
                    is_pm_d = ~is_pm_q;
                end else begin
                    hours_d = HOUR_W'(hours_q - HOUR_W'(1));
                end
            end else begin
                minutes_d = (minutes_q == '0) ? MIN_W'(59) : MIN_W'(minutes_q - MIN_W'(1));
            end
        end
    end

    // All state; reset also captures button levels so a held button is not a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HOUR;
            hours_q     <= HOUR_W'(12);
            minutes_q   <= '0;
            is_pm_q     <= 1'b0;
            propagate_q <= 1'b0;
            prev_set_q  <= set;
            prev_up_q   <= up;
            prev_down_q <= down;
`ifdef SET12_AUTOREPEAT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            is_pm_q     <= is_pm_d;
            propagate_q <= propagate_d;
            prev_set_q  <= set;
            prev_up_q   <= up;
            prev_down_q <= down;
`ifdef SET12_AUTOREPEAT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign propagate = propagate_q;
    assign isPM      = is_pm_q;
    assign hours     = hours_q;
    assign minutes   = minutes_q;

endmodule

// File: tb/tb_set12.sv
// Scoreboard bench for set12: stimulus queues expected outputs per cycle, a monitor compares them.
module tb_set12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       set, up, down;
    logic       propagate, isPM;
    logic [3:0] hours;
    logic [5:0] minutes;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at_cyc;
        string      name;
        logic [3:0] h;
        logic [5:0] m;
        logic       pm;
        logic       prop;
    } exp_t;

    exp_t exp_q[$];

    set12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (set),
        .up        (up),
        .down      (down),
        .propagate (propagate),
        .isPM      (isPM),
        .hours     (hours),
        .minutes   (minutes)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due this cycle, mid-cycle away from the edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at_cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.at_cyc != cyc) begin
                errors++;
                $display("FAIL %s missed its sample cycle (due %0d, now %0d)", e.name, e.at_cyc, cyc);
            end else if (hours !== e.h || minutes !== e.m || isPM !== e.pm || propagate !== e.prop) begin
                errors++;
                $display("FAIL %s got h=%0d m=%0d pm=%0b prop=%0b want h=%0d m=%0d pm=%0b prop=%0b",
                         e.name, hours, minutes, isPM, propagate, e.h, e.m, e.pm, e.prop);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected after the following edge.
    task automatic step(input string name, input logic r, input logic s, input logic u,
                        input logic d, input int eh, input int em, input logic epm,
                        input logic eprop);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        set   = s;
        up    = u;
        down  = d;
        e.at_cyc = cyc + 1;
        e.name   = name;
        e.h      = 4'(eh);
        e.m      = 6'(em);
        e.pm     = epm;
        e.prop   = eprop;
        exp_q.push_back(e);
    endtask

    int held_exp;

    initial begin
        rst_n = 1'b0;
        set   = 1'b0;
        up    = 1'b0;
        down  = 1'b0;

        // Reset with up held: the held button must not count as a press afterwards.
        step("reset",            0, 0, 1, 0, 12, 0, 0, 0);
        step("held_thru_reset",  1, 0, 1, 0, 12, 0, 0, 0);
        step("release",          1, 0, 0, 0, 12, 0, 0, 0);
        step("up_12_to_1",       1, 0, 1, 0,  1, 0, 0, 0);
        step("up_rel",           1, 0, 0, 0,  1, 0, 0, 0);

        // Enter MINUTE, exercise both wraps.
        step("set_to_min",       1, 1, 0, 0,  1, 0, 0, 0);
        step("set_rel",          1, 0, 0, 0,  1, 0, 0, 0);
        step("min_up",           1, 0, 1, 0,  1, 1, 0, 0);
        step("min_up_rel",       1, 0, 0, 0,  1, 1, 0, 0);
        step("min_down",         1, 0, 0, 1,  1, 0, 0, 0);
        step("min_down_rel",     1, 0, 0, 0,  1, 0, 0, 0);
        step("min_wrap_down",    1, 0, 0, 1,  1, 59, 0, 0);
        step("min_wrap_rel",     1, 0, 0, 0,  1, 59, 0, 0);
        step("min_wrap_up",      1, 0, 1, 0,  1, 0, 0, 0);
        step("min_wrap_up_rel",  1, 0, 0, 0,  1, 0, 0, 0);

        // Second set press commits and pulses propagate for exactly one cycle.
        step("prop_pulse",       1, 1, 0, 0,  1, 0, 0, 1);
        step("prop_clear",       1, 0, 0, 0,  1, 0, 0, 0);
        step("prop_stays_low",   1, 0, 0, 0,  1, 0, 0, 0);

        // Back in HOUR: walk up to 11 AM.
        step("hour_up_2",        1, 0, 1, 0,  2, 0, 0, 0);
        step("hour_rel_2",       1, 0, 0, 0,  2, 0, 0, 0);
        step("hour_up_3",        1, 0, 1, 0,  3, 0, 0, 0);
        step("hour_rel_3",       1, 0, 0, 0,  3, 0, 0, 0);
        step("hour_up_4",        1, 0, 1, 0,  4, 0, 0, 0);
        step("hour_rel_4",       1, 0, 0, 0,  4, 0, 0, 0);
        step("hour_up_5",        1, 0, 1, 0,  5, 0, 0, 0);
        step("hour_rel_5",       1, 0, 0, 0,  5, 0, 0, 0);
        step("hour_up_6",        1, 0, 1, 0,  6, 0, 0, 0);
        step("hour_rel_6",       1, 0, 0, 0,  6, 0, 0, 0);
        step("hour_up_7",        1, 0, 1, 0,  7, 0, 0, 0);
        step("hour_rel_7",       1, 0, 0, 0,  7, 0, 0, 0);
        step("hour_up_8",        1, 0, 1, 0,  8, 0, 0, 0);
        step("hour_rel_8",       1, 0, 0, 0,  8, 0, 0, 0);
        step("hour_up_9",        1, 0, 1, 0,  9, 0, 0, 0);
        step("hour_rel_9",       1, 0, 0, 0,  9, 0, 0, 0);
        step("hour_up_10",       1, 0, 1, 0, 10, 0, 0, 0);
        step("hour_rel_10",      1, 0, 0, 0, 10, 0, 0, 0);
        step("hour_up_11",       1, 0, 1, 0, 11, 0, 0, 0);
        step("hour_rel_11",      1, 0, 0, 0, 11, 0, 0, 0);

        // AM/PM toggles at the 11<->12 boundary only.
        step("up_11_to_12_pm",   1, 0, 1, 0, 12, 0, 1, 0);
        step("rel_a",            1, 0, 0, 0, 12, 0, 1, 0);
        step("down_12_to_11_am", 1, 0, 0, 1, 11, 0, 0, 0);
        step("rel_b",            1, 0, 0, 0, 11, 0, 0, 0);
        step("up_11_to_12_pm2",  1, 0, 1, 0, 12, 0, 1, 0);
        step("rel_c",            1, 0, 0, 0, 12, 0, 1, 0);
        step("up_12_to_1_pm",    1, 0, 1, 0,  1, 0, 1, 0);
        step("rel_d",            1, 0, 0, 0,  1, 0, 1, 0);
        step("down_1_to_12_pm",  1, 0, 0, 1, 12, 0, 1, 0);
        step("rel_e",            1, 0, 0, 0, 12, 0, 1, 0);
        step("up_12_to_1_again", 1, 0, 1, 0,  1, 0, 1, 0);
        step("rel_f",            1, 0, 0, 0,  1, 0, 1, 0);

        // set+up together: set wins, hours unchanged, now in MINUTE.
        step("set_up_same",      1, 1, 1, 0,  1, 0, 1, 0);
        step("rel_g",            1, 0, 0, 0,  1, 0, 1, 0);
        step("in_minute_up",     1, 0, 1, 0,  1, 1, 1, 0);
        step("rel_h",            1, 0, 0, 0,  1, 1, 1, 0);
        step("up_down_cancel",   1, 0, 1, 1,  1, 1, 1, 0);
        step("rel_i",            1, 0, 0, 0,  1, 1, 1, 0);

        // Reset mid-edit overrides a set press.
        step("reset_mid_edit",   0, 1, 0, 0, 12, 0, 0, 0);
        step("post_reset",       1, 0, 0, 0, 12, 0, 0, 0);
        step("hour_after_rst",   1, 0, 1, 0,  1, 0, 0, 0);
        step("rel_j",            1, 0, 0, 0,  1, 0, 0, 0);

        // Hold up for 40 cycles from hours=1.
        for (int j = 0; j < 40; j++) begin
`ifdef SET12_AUTOREPEAT_EN
            held_exp = 2 + ((j >= 16) ? ((j - 16) / 4 + 1) : 0);
`else
            held_exp = 2;
`endif
            step($sformatf("held_up_%0d", j), 1, 0, 1, 0, held_exp, 0, 0, 0);
        end
`ifdef SET12_AUTOREPEAT_EN
        held_exp = 8;
`else
        held_exp = 2;
`endif
        step("held_release",     1, 0, 0, 0, held_exp, 0, 0, 0);
        step("held_idle",        1, 0, 0, 0, held_exp, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/set12.md
SET12 -- requirements
Module: set12

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 set  input  1  level button; a rising transition advances the edit field.
REQ-005 up  input  1  level button; a rising transition increments the selected field.
REQ-006 down  input  1  level button; a rising transition decrements the selected field.
REQ-007 propagate  output  1  one-cycle pulse signalling the set time is committed.
REQ-008 isPM  output  1  0 = AM, 1 = PM.
REQ-009 hours  output  4  hour value, always in 1..12.
REQ-010 minutes  output  6  minute value, always in 0..59.

Function
REQ-011 Each button SHALL be registered once per cycle (prev_*); a press is detected when the input is 1 and prev_* is 0 at a clk edge; the resulting update takes effect at that same edge (outputs change one edge after the input rises).
REQ-012 Holding a button SHALL produce exactly one press, unless the auto-repeat feature in REQ-026 is compiled in.
REQ-013 Edit state machine with two states, HOUR (reset state) and MINUTE: a set press in HOUR moves to MINUTE; a set press in MINUTE moves to HOUR and pulses propagate high for exactly one cycle.
REQ-014 In HOUR, an up press: 12->1 with isPM unchanged; 11->12 toggles isPM; any other value increments by 1.
REQ-015 In HOUR, a down press: 1->12 with isPM unchanged; 12->11 toggles isPM; any other value decrements by 1.
REQ-016 In MINUTE, an up press: 59->0, otherwise +1; hours and isPM are never affected.
REQ-017 In MINUTE, a down press: 0->59, otherwise -1; hours and isPM are never affected.
REQ-018 Simultaneous presses: a set press has priority and any up/down press in the same cycle is discarded; an up and a down press in the same cycle are both ignored.
REQ-019 propagate SHALL be 0 in every cycle except the one following the MINUTE->HOUR transition edge.
REQ-020 Outputs SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-021 While rst_n = 0 at a clk edge: hours = 12, minutes = 0, isPM = 0, propagate = 0, state = HOUR.
REQ-022 On the same edge, all prev_* registers SHALL load the current input values, so a button held through reset does not register a press.
REQ-023 Reset SHALL override any press in the same cycle, including mid-edit in MINUTE.
REQ-024 There is no power-on reset assumption beyond rst_n.

Configuration
REQ-025 Macro SET12_AUTOREPEAT_EN SHALL select the auto-repeat feature.
REQ-026 With SET12_AUTOREPEAT_EN defined: when up or down is held continuously for 16 cycles after its press, an additional press SHALL be generated, then one every 4 cycles while held; a 5-bit hold counter clears on release, on reset, or on a set press.
REQ-027 Without SET12_AUTOREPEAT_EN: no hold counter is built, and behaviour is exactly one press per rising transition.

Verification
REQ-028 Reset, then set=up=down=0 -> hours=12, minutes=0, isPM=0, propagate=0.
REQ-029 After reset, pulse up for 1 cycle in HOUR -> hours=1, isPM=0; pulse set, then pulse up -> minutes=1, hours=1.
REQ-030 From hours=11, isPM=0, up press -> hours=12, isPM=1; then down press -> hours=11, isPM=0.
REQ-031 In MINUTE with minutes=0, down press -> 59; then up press -> 0; hours unchanged.
REQ-032 Two set presses from HOUR -> propagate high for exactly one cycle after the second press; state returns to HOUR.
REQ-033 set and up rise in the same cycle in HOUR -> state becomes MINUTE and hours unchanged; up held 40 cycles -> one increment only, unless SET12_AUTOREPEAT_EN is defined, in which case 1+1+5 = 7 increments.
